stream_mux_rr: RTL and testbench

Parametrised N-input, WIDTH-bit streaming multiplexer with valid/ready handshakes, round-robin arbitration and a registered output stage. It supersedes the fixed 4×4-bit select-driven mux in datapaths where several producers share one consumer. Selection is by fair arbitration rather than an external select. An optional forced-select mode restores direct steering.

---
 rtl/stream_mux_pkg.sv | 34 +++
 rtl/stream_mux_rr_arbiter.sv | 33 +++
 rtl/stream_mux_rr.sv | 76 +++++++
 tb/tb_stream_mux_rr.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for stream_mux_rr: cyclic round-robin search
// and the reset value of the priority pointer.
package stream_mux_pkg;
   localparam int MAX_N = 64;
   localparam int IDXW  = 6;

   typedef struct packed {
      logic            found;
      logic [IDXW-1:0] idx;
   } rr_res_t;

   // Pointer resets to the last channel so channel 0 wins first.
   function automatic int rr_ptr_rst(input int n);
      return n - 1;
   endfunction

   // First set bit of req searching ptr+1 .. ptr (mod n).
   function automatic rr_res_t rr_next(input logic [MAX_N-1:0] req,
                                       input logic [IDXW-1:0]  ptr,
                                       input int               n);
      rr_res_t        r;
      logic [IDXW:0]  j;
      r = '0;
      for (int k = 1; k <= MAX_N; k++) begin
         j = {1'b0, ptr} + (IDXW+1)'(k);
         if (j >= (IDXW+1)'(n)) j = j - (IDXW+1)'(n);
         if (k <= n && !r.found && req[j[IDXW-1:0]]) begin
            r.found = 1'b1;
            r.idx   = j[IDXW-1:0];
         end
      end
      return r;
   endfunction
endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus its index.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter  int N    = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [SELW-1:0] grant_idx
);
   logic [MAX_N-1:0] req_x;
   logic [IDXW-1:0]  ptr_x;
   rr_res_t          r;

   always_comb begin
      req_x          = '0;
      req_x[N-1:0]   = req;
      ptr_x          = '0;
      ptr_x[SELW-1:0] = ptr;
      r              = rr_next(req_x, ptr_x, N);
      grant_idx      = r.idx[SELW-1:0];
      grant          = r.found ? (N'(1) << r.idx[SELW-1:0]) : '0;
   end

   generate
      if (SELW < IDXW) begin : g_unused
         logic unused_idx_hi;
         assign unused_idx_hi = ^r.idx[IDXW-1:SELW];
      end
   endgenerate
endmodule

// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream mux, round-robin arbitration, registered output.
// Optional forced select under `define STREAM_MUX_FORCE_SEL_EN.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int WIDTH = 4,
   localparam int SELW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_ch,
`ifdef STREAM_MUX_FORCE_SEL_EN
   input  logic               force_en,
   input  logic [SELW-1:0]    force_sel,
`endif
   input  logic               out_ready
);
   localparam logic [SELW-1:0] PTR_RST = SELW'(rr_ptr_rst(N));

   logic [N-1:0][WIDTH-1:0] din;
   logic [SELW-1:0]         ptr;
   logic [N-1:0]            rr_grant, grant;
   logic [SELW-1:0]         rr_idx, gidx;
   logic                    load, xfer;

   assign din = in_data;

   rr_arbiter #(.N(N)) u_arb (
      .req       (in_valid),
      .ptr       (ptr),
      .grant     (rr_grant),
      .grant_idx (rr_idx)
   );

`ifdef STREAM_MUX_FORCE_SEL_EN
   // Out-of-range force_sel matches no channel, so it yields no grant.
   always_comb begin
      grant = rr_grant;
      gidx  = rr_idx;
      if (force_en) begin
         gidx = force_sel;
         for (int i = 0; i < N; i++)
            grant[i] = (force_sel == SELW'(i)) && in_valid[i];
      end
   end
`else
   assign grant = rr_grant;
   assign gidx  = rr_idx;
`endif

   assign load     = !out_valid || out_ready;
   assign in_ready = (load && !rst) ? grant : '0;
   assign xfer     = |in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= PTR_RST;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= din[gidx];
         out_ch    <= gidx;
         ptr       <= gidx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr (N=4, WIDTH=4).
module tb_stream_mux_rr;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  in_valid = '0;
   logic [15:0] in_data = '0;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [3:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_ready = 1'b0;
`ifdef STREAM_MUX_FORCE_SEL_EN
   logic        force_en = 1'b0;
   logic [1:0]  force_sel = '0;
`endif

   int tests = 0;
   int fails = 0;

   stream_mux_rr #(.N(4), .WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
`ifdef STREAM_MUX_FORCE_SEL_EN
      .force_en  (force_en),
      .force_sel (force_sel),
`endif
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = '0;
      out_ready = 1'b0;
      rst       = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 4'b1111;
      in_data   = 16'hDCBA;
      out_ready = 1'b1;
      step();
      step();
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      tests++;
      if (out_data !== 4'h0) begin fails++; $display("FAIL reset_data: got %h want 0", out_data); end
      tests++;
      if (out_ch !== 2'd0) begin fails++; $display("FAIL reset_ch: got %0d want 0", out_ch); end
      tests++;
      if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
      rst = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_d  [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
      logic [1:0] exp_c  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [3:0] exp_rdy[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      in_valid  = 4'b1111;
      in_data   = 16'hDCBA;
      out_ready = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (in_ready !== exp_rdy[i]) begin fails++; $display("FAIL rr_ready[%0d]: got %b want %b", i, in_ready, exp_rdy[i]); end
         step();
         tests++;
         if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_ch !== exp_c[i]) begin
            fails++;
            $display("FAIL rr_out[%0d]: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                     i, out_valid, out_data, out_ch, exp_d[i], exp_c[i]);
         end
      end
      in_valid = '0;
      step();
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL rr_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      do_reset();
      in_valid  = 4'b0100;
      in_data   = 16'h0500;
      out_ready = 1'b0;
      #1;
      tests++;
      if (in_ready !== 4'b0100) begin fails++; $display("FAIL bp_first_ready: got %b want 0100", in_ready); end
      step();
      in_data = 16'h0600;
      for (int i = 0; i < 5; i++) begin
         #1;
         tests++;
         if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 4'h5 || out_ch !== 2'd2) begin
            fails++;
            $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h ch=%0d want rdy=0000 v=1 d=5 ch=2",
                     i, in_ready, out_valid, out_data, out_ch);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      tests++;
      if (in_ready !== 4'b0100) begin fails++; $display("FAIL bp_release_ready: got %b want 0100", in_ready); end
      step();
      in_valid = '0;
      tests++;
      if (out_valid !== 1'b1 || out_data !== 4'h6) begin
         fails++; $display("FAIL bp_next_word: got v=%b d=%h want v=1 d=6", out_valid, out_data);
      end
      step();
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_fairness();
      logic [1:0] exp_c[7] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
      do_reset();
      in_data   = 16'h0301;
      in_valid  = 4'b0001;
      out_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if (c == 3) in_valid = 4'b0101;
         step();
         tests++;
         if (out_valid !== 1'b1 || out_ch !== exp_c[c]) begin
            fails++; $display("FAIL fair_ch[%0d]: got v=%b ch=%0d want v=1 ch=%0d", c, out_valid, out_ch, exp_c[c]);
         end
      end
      in_valid = '0;
   endtask

   task automatic test_drain_load();
      do_reset();
      in_valid  = 4'b0001;
      in_data   = 16'h0007;
      out_ready = 1'b1;
      step();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 4'h7) begin
         fails++; $display("FAIL dl_first: got v=%b d=%h want v=1 d=7", out_valid, out_data);
      end
      in_data = 16'h0008;
      step();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 4'h8 || out_ch !== 2'd0) begin
         fails++; $display("FAIL dl_replace: got v=%b d=%h ch=%0d want v=1 d=8 ch=0", out_valid, out_data, out_ch);
      end
   endtask

   task automatic test_reset_mid();
      // Follows test_drain_load: word held and ptr at channel 0.
      in_valid  = 4'b1111;
      in_data   = 16'hDCBA;
      out_ready = 1'b0;
      rst       = 1'b1;
      step();
      tests++;
      if (out_valid !== 1'b0 || out_data !== 4'h0 || out_ch !== 2'd0) begin
         fails++; $display("FAIL mid_rst: got v=%b d=%h ch=%0d want v=0 d=0 ch=0", out_valid, out_data, out_ch);
      end
      rst       = 1'b0;
      out_ready = 1'b1;
      #1;
      tests++;
      if (in_ready !== 4'b0001) begin fails++; $display("FAIL mid_rst_grant: got %b want 0001", in_ready); end
      step();
      tests++;
      if (out_data !== 4'hA || out_ch !== 2'd0) begin
         fails++; $display("FAIL mid_rst_out: got d=%h ch=%0d want d=A ch=0", out_data, out_ch);
      end
      in_valid = '0;
   endtask

`ifdef STREAM_MUX_FORCE_SEL_EN
   task automatic test_force();
      do_reset();
      force_en  = 1'b1;
      force_sel = 2'd3;
      in_valid  = 4'b1111;
      in_data   = 16'hDCBA;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if (in_ready !== 4'b1000) begin fails++; $display("FAIL force_ready[%0d]: got %b want 1000", i, in_ready); end
         step();
         tests++;
         if (out_data !== 4'hD || out_ch !== 2'd3) begin
            fails++; $display("FAIL force_out[%0d]: got d=%h ch=%0d want d=D ch=3", i, out_data, out_ch);
         end
      end
      in_valid = 4'b0111;
      #1;
      tests++;
      if (in_ready !== 4'b0000) begin fails++; $display("FAIL force_nogrant: got %b want 0000", in_ready); end
      step();
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL force_empty: got %b want 0", out_valid); end
      // ptr was left at 3 by the forced transfers, so channel 0 is next.
      force_en = 1'b0;
      #1;
      tests++;
      if (in_ready !== 4'b0001) begin fails++; $display("FAIL force_ptr: got %b want 0001", in_ready); end
      in_valid = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin();
      test_backpressure();
      test_fairness();
      test_drain_load();
      test_reset_mid();
`ifdef STREAM_MUX_FORCE_SEL_EN
      test_force();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
